ext_sequencer: RTL and testbench

//  Multi-cycle sequencer for extension-opcode instructions (decoder extensionModuleSelect 1=AES-128 enc, 2=dec).

---
 rtl/ext_pkg.sv | 25 ++
 rtl/ext_block_buf.sv | 32 +++
 rtl/ext_sequencer.sv | 170 +++++++++++++++++
 tb/tb_ext_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// Shared types and constants for the extension-opcode sequencer.
package ext_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    AES_GO,
    AES_WAIT,
    WR,
    DONE
  } ext_state_e;

  localparam logic [2:0] EXT_NONE    = 3'd0;
  localparam logic [2:0] EXT_AES_ENC = 3'd1;
  localparam logic [2:0] EXT_AES_DEC = 3'd2;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 128;

  function automatic logic is_aes(input logic [2:0] sel);
    return (sel == EXT_AES_ENC) || (sel == EXT_AES_DEC);
  endfunction

endpackage

// File: rtl/ext_block_buf.sv
// 128-bit block buffer: word-indexed fill from memory, full-block load from the AES core.
module ext_block_buf
  import ext_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              word_we,
  input  logic [1:0]        word_idx,
  input  logic [WORD_W-1:0] word_in,
  input  logic              blk_we,
  input  logic [BLK_W-1:0]  blk_in,
  input  logic [1:0]        rd_idx,
  output logic [BLK_W-1:0]  blk_out,
  output logic [WORD_W-1:0] word_out
);

  logic [BLK_W-1:0] data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
    end else if (blk_we) begin
      data <= blk_in;
    end else if (word_we) begin
      data[{word_idx, 5'b00000} +: WORD_W] <= word_in;
    end
  end

  assign blk_out  = data;
  assign word_out = data[{rd_idx, 5'b00000} +: WORD_W];

endmodule

// File: rtl/ext_sequencer.sv
// Multi-cycle sequencer streaming 128-bit blocks from memory through the AES core and back.
module ext_sequencer
  import ext_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        extSel,
  input  logic [ADDR_W-1:0] srcAddr,
  input  logic [ADDR_W-1:0] dstAddr,
  input  logic [CNT_W-1:0]  wordCount,
  output logic              stall,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRE,
  output logic              memWE,
  output logic [3:0]        memByteena,
  output logic [31:0]       memWData,
  input  logic              memReady,
  input  logic [31:0]       memRData,
  input  logic              memRValid,
  output logic              aesStart,
  output logic              aesDecrypt,
  output logic [127:0]      aesIn,
  input  logic [127:0]      aesOut,
  input  logic              aesDone,
  output logic              done
);

  ext_state_e        state, state_nx;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [CNT_W-1:0]  cnt_q, blk_q;
  logic [1:0]        idx_q;
  logic              dec_q;
  logic              start_ok;
  logic [ADDR_W-1:0] offset, base;
  logic [BLK_W-1:0]  buf_blk;
  logic [WORD_W-1:0] buf_word;

  assign start_ok = is_aes(extSel) && (wordCount != '0);
  assign offset   = ADDR_W'({blk_q, 4'b0000}) + ADDR_W'({idx_q, 2'b00});
  assign base     = (state == WR) ? dst_q : src_q;

  ext_block_buf u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .word_we  ((state == RD_WAIT) && memRValid),
    .word_idx (idx_q),
    .word_in  (memRData),
    .blk_we   ((state == AES_WAIT) && aesDone),
    .blk_in   (aesOut),
    .rd_idx   (idx_q),
    .blk_out  (buf_blk),
    .word_out (buf_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
      blk_q <= '0;
      idx_q <= '0;
      dec_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            src_q <= srcAddr;
            dst_q <= dstAddr;
            cnt_q <= wordCount;
            dec_q <= (extSel == EXT_AES_DEC);
            blk_q <= '0;
            idx_q <= '0;
          end
        end
        RD_WAIT: begin
          if (memRValid) idx_q <= idx_q + 2'd1;
        end
        WR: begin
          // idx wraps 3->0 naturally, which is the start of the next block
          if (memReady) begin
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) blk_q <= blk_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          state_nx = RD_REQ;
        end else if (extSel != EXT_NONE) begin
          state_nx = DONE;
        end
      end
      RD_REQ:   if (memReady) state_nx = RD_WAIT;
      RD_WAIT:  if (memRValid) state_nx = (idx_q == 2'd3) ? AES_GO : RD_REQ;
      AES_GO:   state_nx = AES_WAIT;
      AES_WAIT: if (aesDone) state_nx = WR;
      WR: begin
        if (memReady && (idx_q == 2'd3)) begin
          state_nx = (blk_q == cnt_q - 1'b1) ? DONE : RD_REQ;
        end
      end
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so an abort is visible immediately.
  always_comb begin
    stall      = 1'b0;
    memAddr    = '0;
    memRE      = 1'b0;
    memWE      = 1'b0;
    memByteena = '0;
    memWData   = '0;
    aesStart   = 1'b0;
    aesDecrypt = 1'b0;
    aesIn      = '0;
    done       = 1'b0;
    if (rst_n) begin
      unique case (state)
        IDLE: stall = (extSel != EXT_NONE);
        RD_REQ: begin
          stall      = 1'b1;
          aesDecrypt = dec_q;
          memRE      = 1'b1;
          memAddr    = base + offset;
        end
        RD_WAIT, AES_WAIT: begin
          stall      = 1'b1;
          aesDecrypt = dec_q;
        end
        AES_GO: begin
          stall      = 1'b1;
          aesDecrypt = dec_q;
          aesStart   = 1'b1;
          aesIn      = buf_blk;
        end
        WR: begin
          stall      = 1'b1;
          aesDecrypt = dec_q;
          memWE      = 1'b1;
          memByteena = '1;
          memAddr    = base + offset;
          memWData   = buf_word;
        end
        DONE: done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_sequencer.sv
// Scoreboard bench for ext_sequencer with behavioural memory and AES-core stubs.
module tb_ext_sequencer;
  import ext_pkg::*;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MASK = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   extSel;
  logic [31:0]  srcAddr, dstAddr;
  logic [11:0]  wordCount;
  logic         stall, memRE, memWE, memReady, memRValid;
  logic [31:0]  memAddr, memWData, memRData;
  logic [3:0]   memByteena;
  logic         aesStart, aesDecrypt, aesDone, done;
  logic [127:0] aesIn, aesOut;

  ext_sequencer #(.ADDR_W(32), .CNT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .extSel(extSel), .srcAddr(srcAddr), .dstAddr(dstAddr),
    .wordCount(wordCount), .stall(stall), .memAddr(memAddr), .memRE(memRE), .memWE(memWE),
    .memByteena(memByteena), .memWData(memWData), .memReady(memReady), .memRData(memRData),
    .memRValid(memRValid), .aesStart(aesStart), .aesDecrypt(aesDecrypt), .aesIn(aesIn),
    .aesOut(aesOut), .aesDone(aesDone), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0, n_bad = 0;
  int          exp_done = 0;
  int          wr_hold = 0;
  logic [31:0]  mem [bit [31:0]];
  logic [31:0]  exp_rd[$];
  logic [63:0]  exp_wr[$];
  logic [128:0] exp_aes[$];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a * 32'h9E3779B1;
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] b, input logic dec);
    if (!dec && b == PT) return CT;
    return dec ? ~(b ^ MASK) : (b ^ MASK);
  endfunction

  task automatic expect_instr(input logic [2:0] sel, input logic [31:0] src, input logic [31:0] dst,
                              input int unsigned cnt);
    logic [127:0] b, r;
    logic [31:0]  a;
    for (int unsigned k = 0; k < cnt; k++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        a = src + k * 16 + i * 4;
        exp_rd.push_back(a);
        b[i*32 +: 32] = mem_rd(a);
      end
      exp_aes.push_back({sel == EXT_AES_DEC, b});
      r = aes_model(b, sel == EXT_AES_DEC);
      for (int unsigned i = 0; i < 4; i++) begin
        a = dst + k * 16 + i * 4;
        exp_wr.push_back({a, r[i*32 +: 32]});
      end
    end
    exp_done++;
  endtask

  // Memory and AES core stubs; inputs change 1 time unit after each rising edge.
  initial begin
    logic         rd_pend = 1'b0;
    logic [31:0]  rd_addr = '0;
    int           aes_cnt = 0;
    logic [127:0] aes_res = '0;
    memReady = 1'b0; memRValid = 1'b0; memRData = '0; aesDone = 1'b0; aesOut = '0;
    forever begin
      @(posedge clk); #1;
      memRValid = 1'b0;
      aesDone   = 1'b0;
      if (rd_pend) begin
        memRValid = 1'b1;
        memRData  = mem_rd(rd_addr);
        rd_pend   = 1'b0;
      end
      if (aes_cnt > 0) begin
        aes_cnt--;
        if (aes_cnt == 0) begin
          aesDone = 1'b1;
          aesOut  = aes_res;
        end
      end
      if (aesStart) begin
        aes_cnt = 3;
        aes_res = aes_model(aesIn, aesDecrypt);
      end
      if (memWE && wr_hold > 0) begin
        memReady = 1'b0;
        wr_hold--;
      end else begin
        memReady = 1'b1;
      end
      if (memRE && memReady) begin
        rd_pend = 1'b1;
        rd_addr = memAddr;
      end
      if (memWE && memReady) mem[memAddr] = memWData;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transaction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (memRE || memWE) check("rd_wr_exclusive", {159'd0, memRE & memWE}, '0);
      if (memRE && memReady) begin
        if (exp_rd.size() == 0) check("rd_unexpected", {128'd0, memAddr}, '1);
        else check("rd_addr", {128'd0, memAddr}, {128'd0, exp_rd.pop_front()});
      end
      if (memWE && memReady) begin
        if (exp_wr.size() == 0) check("wr_unexpected", {96'd0, memAddr, memWData}, '1);
        else check("wr", {92'd0, memByteena, memAddr, memWData}, {92'd0, 4'hf, exp_wr.pop_front()});
      end
      if (aesStart) begin
        if (exp_aes.size() == 0) check("aes_unexpected", {31'd0, aesDecrypt, aesIn}, '1);
        else check("aes_start", {31'd0, aesDecrypt, aesIn}, {31'd0, exp_aes.pop_front()});
      end
      if (done) begin
        check("done_expected", {159'd0, exp_done > 0}, 160'd1);
        if (exp_done > 0) exp_done--;
      end
    end
  end

  task automatic issue(input logic [2:0] sel, input logic [31:0] src, input logic [31:0] dst,
                       input logic [11:0] cnt);
    extSel = sel; srcAddr = src; dstAddr = dst; wordCount = cnt;
  endtask

  task automatic wait_done(input string name);
    int unsigned t;
    for (t = 0; t < 500; t++) begin
      @(negedge clk);
      if (done) break;
    end
    if (t == 500) check({name, "_timeout"}, 160'd0, 160'd1);
    @(posedge clk); #1;
    extSel = EXT_NONE;
  endtask

  initial begin
    logic [31:0] a0, d0;
    int unsigned t;
    rst_n = 1'b0;
    issue(EXT_AES_ENC, 32'h100, 32'h200, 12'd1);
    mem[32'h100] = 32'hccddeeff;
    mem[32'h104] = 32'h8899aabb;
    mem[32'h108] = 32'h44556677;
    mem[32'h10C] = 32'h00112233;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {145'd0, stall, memRE, memWE, memByteena, aesStart, aesDecrypt, done, memWData[4:0]}, '0);
    check("reset_data", {memAddr, aesIn}, '0);
    @(posedge clk); #1;
    extSel = EXT_NONE;
    rst_n  = 1'b1;
    @(posedge clk); #1;

    // 1: single encrypt block, FIPS-197 vector
    exp_rd.push_back(32'h100); exp_rd.push_back(32'h104);
    exp_rd.push_back(32'h108); exp_rd.push_back(32'h10C);
    exp_aes.push_back({1'b0, PT});
    exp_wr.push_back({32'h200, 32'h70b4c55a}); exp_wr.push_back({32'h204, 32'hd8cdb780});
    exp_wr.push_back({32'h208, 32'h6a7b0430}); exp_wr.push_back({32'h20C, 32'h69c4e0d8});
    exp_done++;
    issue(EXT_AES_ENC, 32'h100, 32'h200, 12'd1);
    wait_done("t1");
    check("t1_mem200", {128'd0, mem_rd(32'h200)}, {128'd0, 32'h70b4c55a});
    check("t1_mem20C", {128'd0, mem_rd(32'h20C)}, {128'd0, 32'h69c4e0d8});

    // 2: decrypt with zero count retires without traffic
    exp_done++;
    issue(EXT_AES_DEC, 32'h100, 32'h800, 12'd0);
    @(negedge clk); check("t2_stall", {158'd0, stall, done}, 160'b10);
    @(negedge clk); check("t2_done", {158'd0, stall, done}, 160'b01);
    @(posedge clk); #1; extSel = EXT_NONE;
    @(negedge clk); check("t2_idle", {158'd0, stall, done}, '0);
    @(posedge clk); #1;

    // 3: three decrypt blocks with source wrapping past 2^32
    expect_instr(EXT_AES_DEC, 32'hFFFFFFE0, 32'h300, 3);
    check("t3_wrap_addr", {128'd0, exp_rd[8]}, {128'd0, 32'h0});
    issue(EXT_AES_DEC, 32'hFFFFFFE0, 32'h300, 12'd3);
    wait_done("t3");

    // 4: write back-pressure holds address, data and stall
    wr_hold = 5;
    expect_instr(EXT_AES_ENC, 32'h400, 32'h500, 1);
    issue(EXT_AES_ENC, 32'h400, 32'h500, 12'd1);
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (memWE) break;
    end
    if (t == 200) check("t4_wr_timeout", 160'd0, 160'd1);
    a0 = memAddr; d0 = memWData;
    check("t4_first_addr", {128'd0, a0}, {128'd0, 32'h500});
    for (int i = 0; i < 5; i++) begin
      check("t4_hold", {94'd0, stall, memWE, memReady, memAddr, memWData}, {94'd0, 3'b110, a0, d0});
      @(negedge clk);
    end
    check("t4_release", {95'd0, memReady, memAddr, memWData}, {95'd0, 1'b1, a0, d0});
    wait_done("t4");

    // 5: reset while waiting on AES, late aesDone ignored
    exp_rd.push_back(32'h100); exp_rd.push_back(32'h104);
    exp_rd.push_back(32'h108); exp_rd.push_back(32'h10C);
    exp_aes.push_back({1'b0, PT});
    issue(EXT_AES_ENC, 32'h100, 32'h700, 12'd1);
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (aesStart) break;
    end
    if (t == 200) check("t5_start_timeout", 160'd0, 160'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; extSel = EXT_NONE;
    @(negedge clk);
    check("t5_in_reset", {155'd0, stall, memRE, memWE, aesStart, done}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_idle", {154'd0, stall, memRE, memWE, aesStart, aesDecrypt, done}, '0);
    end
    check("t5_no_write", {159'd0, mem.exists(32'h700)}, '0);
    @(posedge clk); #1;
    expect_instr(EXT_AES_ENC, 32'h100, 32'h600, 1);
    issue(EXT_AES_ENC, 32'h100, 32'h600, 12'd1);
    wait_done("t5_reissue");
    check("t5_mem600", {128'd0, mem_rd(32'h600)}, {128'd0, 32'h70b4c55a});

    // 6: unassigned extension select retires; held select in DONE does not restart
    exp_done++;
    issue(3'd5, 32'h100, 32'h900, 12'd1);
    @(negedge clk); check("t6_stall", {158'd0, stall, done}, 160'b10);
    @(negedge clk); check("t6_done", {158'd0, stall, done}, 160'b01);
    @(posedge clk); #1; extSel = EXT_NONE;
    @(negedge clk); check("t6_no_restart", {157'd0, stall, done, memRE}, '0);
    repeat (2) @(negedge clk);

    check("rd_queue_empty", exp_rd.size(), 0);
    check("wr_queue_empty", exp_wr.size(), 0);
    check("aes_queue_empty", exp_aes.size(), 0);
    check("done_all_seen", exp_done, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
